calc_operand_entry: RTL and testbench

Decimal operand entry front end for the calculator. Accepts debounced single-digit strobes from the switch/button layer, buffers up to MAX_DIGITS BCD digits, and on an enter strobe converts them sequentially (one digit per cycle, acc = acc*10 + digit) into a WIDTH-bit binary operand. The operand is presented to the operand registers over a valid/ready handshake. This block is the input-side counterpart of the binary-to-display path: decimal in, binary out.

---
 rtl/calc_pkg.sv | 13 +
 rtl/calc_operand_entry_if.sv | 14 +
 rtl/calc_bcd_mac.sv | 21 ++
 rtl/calc_operand_entry.sv | 193 +++++++++++++++++++
 tb/tb_calc_operand_entry.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator decimal operand entry path.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } calc_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int unsigned COUNT_W = 3;

endpackage

// File: rtl/calc_operand_entry_if.sv
// Operand handshake between the entry front end and the operand registers.
interface calc_operand_entry_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic [WIDTH-1:0] out_value;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  modport master (output out_value, output out_valid, output overflow, input out_ready);
  modport slave  (input out_value, input out_valid, input overflow, output out_ready);

endinterface

// File: rtl/calc_bcd_mac.sv
// One decimal accumulation step: sum = acc*10 + digit, flagging results above 2^WIDTH-1.
module calc_bcd_mac #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH+3:0] acc,
  input  logic [3:0]       digit,
  output logic [WIDTH+3:0] sum,
  output logic             ovf
);

  localparam int unsigned PW = WIDTH + 8;

  logic [PW-1:0] prod;

  always_comb begin
    prod = (PW'(acc) * PW'(10)) + PW'(digit);
    sum  = prod[WIDTH+3:0];
    ovf  = |prod[PW-1:WIDTH];
  end

endmodule

// File: rtl/calc_operand_entry.sv
// Decimal operand entry: buffers BCD digits, converts MSD-first to binary, offers result via valid/ready.
// Optional signed entry (neg_stb / neg ports) when CALC_ENTRY_NEG_EN is defined.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              digit,
  input  logic                    digit_stb,
  input  logic                    enter_stb,
  input  logic                    clear_stb,
`ifdef CALC_ENTRY_NEG_EN
  input  logic                    neg_stb,
  output logic                    neg,
`endif
  output logic                    busy,
  output logic [COUNT_W-1:0]      digit_count,
  output logic [4*MAX_DIGITS-1:0] disp_bcd,
  calc_operand_entry_if.master    out_if
);

  localparam int unsigned BW = 4 * MAX_DIGITS;
  localparam int unsigned AW = WIDTH + 4;
  localparam logic [AW-1:0] ACC_SAT = {4'b0, {WIDTH{1'b1}}};

  calc_state_e        state_q, state_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic [BW-1:0]      conv_q, conv_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               neg_q, neg_d;

  logic [AW-1:0]      mac_sum;
  logic               mac_ovf;
  logic [WIDTH-1:0]   res_value_c;
  logic               res_ovf_c;

  calc_bcd_mac #(.WIDTH(WIDTH)) u_mac (
    .acc   (acc_q),
    .digit (conv_q[BW-1 -: 4]),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  // Final result from the accumulated magnitude; the sticky flag forces saturation.
`ifdef CALC_ENTRY_NEG_EN
  localparam logic [AW-1:0] LIM_POS = {5'b0, {(WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] LIM_NEG = {4'b0, 1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    res_ovf_c = ovf_q | (neg_q ? (acc_q > LIM_NEG) : (acc_q > LIM_POS));
    if (res_ovf_c)
      res_value_c = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_value_c = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  end

  assign neg = neg_q;
`else
  always_comb begin
    res_ovf_c   = ovf_q;
    res_value_c = ovf_q ? {WIDTH{1'b1}} : acc_q[WIDTH-1:0];
  end

  assign neg_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      bcd_q   <= '0;
      conv_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      conv_q  <= conv_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    conv_d  = conv_q;
    count_d = count_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    value_d = value_q;
    valid_d = valid_q;
    busy_d  = busy_q;
`ifdef CALC_ENTRY_NEG_EN
    neg_d   = neg_q;
`endif

    case (state_q)
      ENTRY: begin
        if (enter_stb) begin
          state_d = CONVERT;
          conv_d  = bcd_q;
          idx_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          if (digit_stb && (digit <= BCD_MAX) && (count_q < COUNT_W'(MAX_DIGITS))) begin
            bcd_d   = {bcd_q[BW-5:0], digit};
            count_d = count_q + COUNT_W'(1);
          end
`ifdef CALC_ENTRY_NEG_EN
          if (neg_stb)
            neg_d = ~neg_q;
`endif
        end
      end
      CONVERT: begin
        // One extra cycle after the last digit registers the saturated result.
        if (idx_q == COUNT_W'(MAX_DIGITS)) begin
          state_d = HOLD;
          value_d = res_value_c;
          ovf_d   = res_ovf_c;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          acc_d  = mac_ovf ? ACC_SAT : mac_sum;
          ovf_d  = ovf_q | mac_ovf;
          conv_d = conv_q << 4;
          idx_d  = idx_q + COUNT_W'(1);
        end
      end
      HOLD: begin
        if (valid_q && out_if.out_ready) begin
          state_d = ENTRY;
          valid_d = 1'b0;
          bcd_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef CALC_ENTRY_NEG_EN
          neg_d   = 1'b0;
`endif
        end
      end
      default: state_d = ENTRY;
    endcase

    // Clear aborts any state; out_value keeps its last completed value.
    if (clear_stb) begin
      state_d = ENTRY;
      bcd_d   = '0;
      conv_d  = '0;
      count_d = '0;
      idx_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
`ifdef CALC_ENTRY_NEG_EN
      neg_d   = 1'b0;
`endif
    end
  end

  assign busy             = busy_q;
  assign digit_count      = count_q;
  assign disp_bcd         = bcd_q;
  assign out_if.out_value = value_q;
  assign out_if.out_valid = valid_q;
  assign out_if.overflow  = ovf_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed self-checking bench for calc_operand_entry (default unsigned build).
module tb_calc_operand_entry;

  logic        clk;
  logic        reset;
  logic [3:0]  digit;
  logic        digit_stb;
  logic        enter_stb;
  logic        clear_stb;
  logic        busy;
  logic [2:0]  digit_count;
  logic [19:0] disp_bcd;

  int n_checks = 0;
  int n_fails  = 0;

  calc_operand_entry_if #(.WIDTH(16)) bus ();

  calc_operand_entry #(.WIDTH(16), .MAX_DIGITS(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit       (digit),
    .digit_stb   (digit_stb),
    .enter_stb   (enter_stb),
    .clear_stb   (clear_stb),
    .busy        (busy),
    .digit_count (digit_count),
    .disp_bcd    (disp_bcd),
    .out_if      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_digit(input logic [3:0] d);
    digit     = d;
    digit_stb = 1'b1;
    tick();
    digit_stb = 1'b0;
  endtask

  task automatic push_number(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                             input logic [3:0] d3, input logic [3:0] d4);
    push_digit(d0);
    push_digit(d1);
    push_digit(d2);
    push_digit(d3);
    push_digit(d4);
  endtask

  task automatic press_enter();
    enter_stb = 1'b1;
    tick();
    enter_stb = 1'b0;
  endtask

  // Counts edges after the enter edge until out_valid, bounded.
  task automatic wait_valid(input string tag);
    int cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check(tag, 32'(cycles), 32'd6);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    digit         = 4'd0;
    digit_stb     = 1'b0;
    enter_stb     = 1'b0;
    clear_stb     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_value", 32'(bus.out_value), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_disp", 32'(disp_bcd), 32'd0);

    // 12345 with a long HOLD stall
    push_number(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    check("disp_12345", 32'(disp_bcd), 32'h12345);
    check("count_5", 32'(digit_count), 32'd5);
    press_enter();
    check("busy_conv", 32'(busy), 32'd1);
    check("valid_conv", 32'(bus.out_valid), 32'd0);
    wait_valid("lat_12345");
    check("val_12345", 32'(bus.out_value), 32'h3039);
    check("ovf_12345", 32'(bus.overflow), 32'd0);
    check("busy_hold", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      digit     = 4'd7;
      digit_stb = i[0];
      enter_stb = ~i[0];
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_value", 32'(bus.out_value), 32'h3039);
    end
    digit_stb = 1'b0;
    enter_stb = 1'b0;
    check("hold_count", 32'(digit_count), 32'd5);
    accept();
    check("acc_valid", 32'(bus.out_valid), 32'd0);
    check("acc_count", 32'(digit_count), 32'd0);
    check("acc_disp", 32'(disp_bcd), 32'd0);
    check("acc_value_kept", 32'(bus.out_value), 32'h3039);

    // 65536 overflows and saturates
    push_number(4'd6, 4'd5, 4'd5, 4'd3, 4'd6);
    press_enter();
    wait_valid("lat_65536");
    check("val_65536", 32'(bus.out_value), 32'hFFFF);
    check("ovf_65536", 32'(bus.overflow), 32'd1);
    accept();
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // 65535 is the exact maximum
    push_number(4'd6, 4'd5, 4'd5, 4'd3, 4'd5);
    press_enter();
    wait_valid("lat_65535");
    check("val_65535", 32'(bus.out_value), 32'hFFFF);
    check("ovf_65535", 32'(bus.overflow), 32'd0);
    accept();

    // Invalid digit and sixth digit ignored
    push_digit(4'd1);
    push_digit(4'hA);
    push_number(4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    check("full_count", 32'(digit_count), 32'd5);
    check("full_disp", 32'(disp_bcd), 32'h12345);
    press_enter();
    wait_valid("lat_full");
    check("val_full", 32'(bus.out_value), 32'd12345);
    accept();

    // Clear during CONVERT aborts
    push_digit(4'd7);
    push_digit(4'd8);
    press_enter();
    tick();
    clear_stb = 1'b1;
    tick();
    clear_stb = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_disp", 32'(disp_bcd), 32'd0);
    check("clr_count", 32'(digit_count), 32'd0);
    begin
      logic seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        seen_valid = seen_valid | bus.out_valid;
      end
      check("clr_no_valid", 32'(seen_valid), 32'd0);
    end

    // Enter with empty buffer yields 0
    press_enter();
    wait_valid("lat_empty");
    check("val_empty", 32'(bus.out_value), 32'd0);
    check("ovf_empty", 32'(bus.overflow), 32'd0);
    accept();

    // Enter beats a simultaneous digit
    push_digit(4'd4);
    push_digit(4'd2);
    digit     = 4'd7;
    digit_stb = 1'b1;
    enter_stb = 1'b1;
    tick();
    digit_stb = 1'b0;
    enter_stb = 1'b0;
    check("simul_count", 32'(digit_count), 32'd2);
    wait_valid("lat_simul");
    check("val_simul", 32'(bus.out_value), 32'd42);
    accept();

    // Clear beats enter in ENTRY
    push_digit(4'd3);
    enter_stb = 1'b1;
    clear_stb = 1'b1;
    tick();
    enter_stb = 1'b0;
    clear_stb = 1'b0;
    check("clr_pri_busy", 32'(busy), 32'd0);
    check("clr_pri_count", 32'(digit_count), 32'd0);

    // Ready held high before valid: transfer on the first edge with both
    bus.out_ready = 1'b1;
    push_digit(4'd9);
    press_enter();
    wait_valid("lat_early_rdy");
    check("val_early_rdy", 32'(bus.out_value), 32'd9);
    tick();
    check("early_rdy_done", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Reset in HOLD clears every output
    push_digit(4'd9);
    push_digit(4'd9);
    press_enter();
    wait_valid("lat_rst_hold");
    check("val_rst_hold", 32'(bus.out_value), 32'd99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rh_valid", 32'(bus.out_valid), 32'd0);
    check("rh_value", 32'(bus.out_value), 32'd0);
    check("rh_count", 32'(digit_count), 32'd0);
    check("rh_disp", 32'(disp_bcd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
